// File: rtl/farm_pkg.sv
// Shared types, channel indices, threshold defaults and hysteresis helpers
// for the farm scan scheduler.
package farm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      GAP    = 2'd2,
      DECIDE = 2'd3
   } state_e;

   localparam logic [1:0] CH_MOIST = 2'd0;
   localparam logic [1:0] CH_TEMP  = 2'd1;
   localparam logic [1:0] CH_LIGHT = 2'd2;
   localparam logic [1:0] CH_HUMID = 2'd3;

   localparam logic [7:0] THR0_DEF = 8'd100;
   localparam logic [7:0] THR1_DEF = 8'd180;
   localparam logic [7:0] THR2_DEF = 8'd60;
   localparam logic [7:0] THR3_DEF = 8'd128;

   // Actuator that turns on when the reading drops below the threshold.
   function automatic logic hyst_below(input logic prev, input logic [7:0] val,
                                       input logic [7:0] thr, input logic [8:0] band);
      logic [8:0] hi;
      hi = {1'b0, thr} + band;
      if (hi > 9'd255) hi = 9'd255;
      if (val < thr) return 1'b1;
      if ({1'b0, val} >= hi) return 1'b0;
      return prev;
   endfunction

   // Actuator that turns on when the reading rises above the threshold.
   function automatic logic hyst_above(input logic prev, input logic [7:0] val,
                                       input logic [7:0] thr, input logic [8:0] band);
      logic [8:0] lo;
      if ({1'b0, thr} < band) lo = 9'd0;
      else                    lo = {1'b0, thr} - band;
      if (val > thr) return 1'b1;
      if ({1'b0, val} <= lo) return 1'b0;
      return prev;
   endfunction

endpackage

// File: rtl/farm_scan_scheduler_if.sv
// Request/acknowledge link between the scheduler and the shared sampler.
interface farm_scan_scheduler_if;
   logic       smp_req;
   logic [1:0] smp_ch;
   logic       smp_ack;
   logic [7:0] smp_data;

   modport master (output smp_req, output smp_ch, input smp_ack, input smp_data);
   modport slave  (input smp_req, input smp_ch, output smp_ack, output smp_data);
endinterface

// File: rtl/farm_tick_gen.sv
// Scan-period divider: one-cycle tick every TICK_DIV cycles while enabled.
module farm_tick_gen #(
   parameter int unsigned TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Counter free-runs while enabled and parks at zero otherwise.
   always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      if (ena) begin
         tick_d = (cnt_q == CNT_LAST);
         cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   // Counter and tick registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/farm_scan_scheduler.sv
// Periodic four-channel sensor scan with per-channel timeout and
// hysteresis-controlled pump, fan and lamp enables.
module farm_scan_scheduler
   import farm_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned TIMEOUT  = 64,
   parameter int unsigned HYST     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic                          start,
   farm_scan_scheduler_if.master         smp,
   input  logic                          thr_wr,
   input  logic [1:0]                    thr_sel,
   input  logic [7:0]                    thr_data,
   output logic                          pump_on,
   output logic                          fan_on,
   output logic                          lamp_on,
   output logic                          busy,
   output logic                          scan_done,
   output logic [3:0]                    fault
);

   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
   localparam logic [8:0]    BAND      = 9'(HYST);

   state_e        state_q, state_d;
   logic [1:0]    ch_q, ch_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [7:0]    sample_q [4];
   logic [7:0]    sample_d [4];
   logic [7:0]    thr_q [4];
   logic [7:0]    thr_d [4];
   logic [3:0]    fault_q, fault_d;
   logic          pump_q, pump_d, fan_q, fan_d, lamp_q, lamp_d;
   logic          done_q, done_d, req_q, req_d, busy_q, busy_d;
   logic          tick;

   farm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .tick  (tick)
   );

   // Next-state, register-file and actuator decision logic.
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      wait_d   = wait_q;
      sample_d = sample_q;
      thr_d    = thr_q;
      fault_d  = fault_q;
      pump_d   = pump_q;
      fan_d    = fan_q;
      lamp_d   = lamp_q;
      done_d   = 1'b0;

      if (thr_wr) thr_d[thr_sel] = thr_data;

      if (!ena && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (ena && (start || tick)) begin
                  state_d = REQ;
                  ch_d    = CH_MOIST;
                  wait_d  = '0;
               end
            end
            REQ: begin
               if (smp.smp_ack) begin
                  sample_d[ch_q] = smp.smp_data;
                  fault_d[ch_q]  = 1'b0;
                  state_d        = GAP;
               end else if (wait_q == WAIT_LAST) begin
                  fault_d[ch_q] = 1'b1;
                  state_d       = GAP;
               end else begin
                  wait_d = wait_q + WW'(1);
               end
            end
            GAP: begin
               if (ch_q == CH_HUMID) begin
                  state_d = DECIDE;
               end else begin
                  state_d = REQ;
                  ch_d    = ch_q + 2'd1;
                  wait_d  = '0;
               end
            end
            DECIDE: begin
               state_d = IDLE;
               done_d  = 1'b1;
               pump_d  = !fault_q[CH_MOIST] &&
                         hyst_below(pump_q, sample_q[CH_MOIST], thr_q[CH_MOIST], BAND);
               fan_d   = !fault_q[CH_TEMP] &&
                         hyst_above(fan_q, sample_q[CH_TEMP], thr_q[CH_TEMP], BAND);
               lamp_d  = !fault_q[CH_LIGHT] &&
                         hyst_below(lamp_q, sample_q[CH_LIGHT], thr_q[CH_LIGHT], BAND);
            end
            default: state_d = IDLE;
         endcase
      end

      req_d  = (state_d == REQ);
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
         wait_q  <= '0;
         for (int i = 0; i < 4; i++) sample_q[i] <= '0;
         thr_q[0] <= THR0_DEF;
         thr_q[1] <= THR1_DEF;
         thr_q[2] <= THR2_DEF;
         thr_q[3] <= THR3_DEF;
         fault_q <= '0;
         pump_q  <= 1'b0;
         fan_q   <= 1'b0;
         lamp_q  <= 1'b0;
         done_q  <= 1'b0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         wait_q   <= wait_d;
         sample_q <= sample_d;
         thr_q    <= thr_d;
         fault_q  <= fault_d;
         pump_q   <= pump_d;
         fan_q    <= fan_d;
         lamp_q   <= lamp_d;
         done_q   <= done_d;
         req_q    <= req_d;
         busy_q   <= busy_d;
      end
   end

   assign smp.smp_req = req_q;
   assign smp.smp_ch  = ch_q;
   assign pump_on     = pump_q;
   assign fan_on      = fan_q;
   assign lamp_on     = lamp_q;
   assign busy        = busy_q;
   assign scan_done   = done_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_farm_scan_scheduler.sv
// Bench for farm_scan_scheduler: responsive sampler, scan-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_farm_scan_scheduler;

   localparam int TD = 16;
   localparam int TO = 64;
   localparam int HY = 4;

   logic       clk = 1'b0;
   logic       rst_n, ena, start, thr_wr;
   logic [1:0] thr_sel;
   logic [7:0] thr_data;
   logic       pump_on, fan_on, lamp_on, busy, scan_done;
   logic [3:0] fault;

   logic [3:0] ack_en;
   logic [7:0] vals [4];
   logic       stray;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   farm_scan_scheduler_if smp_if ();

   farm_scan_scheduler #(.TICK_DIV(TD), .TIMEOUT(TO), .HYST(HY)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .start     (start),
      .smp       (smp_if),
      .thr_wr    (thr_wr),
      .thr_sel   (thr_sel),
      .thr_data  (thr_data),
      .pump_on   (pump_on),
      .fan_on    (fan_on),
      .lamp_on   (lamp_on),
      .busy      (busy),
      .scan_done (scan_done),
      .fault     (fault)
   );

   // Sampler: acks in the first REQ cycle for enabled channels; optional stray ack.
   initial begin
      smp_if.smp_ack  = 1'b0;
      smp_if.smp_data = 8'd0;
      forever begin
         @(posedge clk);
         #2;
         if (stray) begin
            smp_if.smp_ack  = 1'b1;
            smp_if.smp_data = 8'hEE;
         end else begin
            smp_if.smp_ack  = smp_if.smp_req && ack_en[smp_if.smp_ch];
            smp_if.smp_data = vals[smp_if.smp_ch];
         end
      end
   end

   // Reference model: scan progress as channel index plus time spent on it.
   logic       m_tick, m_act, m_req, m_dec, m_done, t_now;
   logic       m_pump, m_fan, m_lamp;
   logic [3:0] m_fault;
   int         m_tcnt, m_ch, m_wait, hi, lo;
   logic [7:0] m_smp [4];
   logic [7:0] m_thr [4];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tcnt = 0; m_tick = 0; m_act = 0; m_req = 0; m_dec = 0; m_done = 0;
         m_ch = 0; m_wait = 0; m_fault = 4'b0;
         m_pump = 0; m_fan = 0; m_lamp = 0;
         for (int i = 0; i < 4; i++) m_smp[i] = 8'd0;
         m_thr[0] = 8'd100; m_thr[1] = 8'd180; m_thr[2] = 8'd60; m_thr[3] = 8'd128;
      end else begin
         t_now  = m_tick;
         m_done = 0;
         if (m_act && !ena) begin
            m_act = 0; m_req = 0; m_dec = 0;
         end else if (!m_act) begin
            if (ena && (start || t_now)) begin
               m_act = 1; m_req = 1; m_ch = 0; m_wait = 0;
            end
         end else if (m_req) begin
            m_wait++;
            if (smp_if.smp_ack) begin
               m_smp[m_ch] = smp_if.smp_data; m_fault[m_ch] = 1'b0; m_req = 0;
            end else if (m_wait == TO) begin
               m_fault[m_ch] = 1'b1; m_req = 0;
            end
         end else if (!m_dec) begin
            if (m_ch == 3) m_dec = 1;
            else begin m_ch++; m_req = 1; m_wait = 0; end
         end else begin
            hi = int'(m_thr[0]) + HY; if (hi > 255) hi = 255;
            if (m_fault[0]) m_pump = 0;
            else if (int'(m_smp[0]) < int'(m_thr[0])) m_pump = 1;
            else if (int'(m_smp[0]) >= hi) m_pump = 0;
            lo = int'(m_thr[1]) - HY; if (lo < 0) lo = 0;
            if (m_fault[1]) m_fan = 0;
            else if (int'(m_smp[1]) > int'(m_thr[1])) m_fan = 1;
            else if (int'(m_smp[1]) <= lo) m_fan = 0;
            hi = int'(m_thr[2]) + HY; if (hi > 255) hi = 255;
            if (m_fault[2]) m_lamp = 0;
            else if (int'(m_smp[2]) < int'(m_thr[2])) m_lamp = 1;
            else if (int'(m_smp[2]) >= hi) m_lamp = 0;
            m_act = 0; m_dec = 0; m_done = 1;
         end
         if (thr_wr) m_thr[thr_sel] = thr_data;
         m_tick = ena && (m_tcnt == TD - 1);
         m_tcnt = ena ? (m_tcnt + 1) % TD : 0;
      end
   end

   // Per-cycle comparison of every output against the model.
   logic [11:0] exp_v, act_v;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         exp_v = {m_act, m_done, m_pump, m_fan, m_lamp, m_fault, m_req,
                  m_req ? 2'(m_ch) : 2'b00};
         act_v = {busy, scan_done, pump_on, fan_on, lamp_on, fault, smp_if.smp_req,
                  smp_if.smp_req ? smp_if.smp_ch : 2'b00};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_bad++;
            if (n_bad <= 20)
               $display("FAIL cycle_model t=%0t dut=%b model=%b", $time, act_v, exp_v);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start-triggered scan; returns cycles from start to scan_done and ch1 REQ cycles.
   task automatic do_scan(output int lat, output int req1);
      lat = 0; req1 = 0;
      ena = 1'b1; start = 1'b1;
      step();
      start = 1'b0; lat = 1;
      while (scan_done !== 1'b1 && lat < 300) begin
         if (smp_if.smp_req && smp_if.smp_ch == 2'd1) req1++;
         step();
         lat++;
      end
      if (lat >= 300) chk("scan_bound", 32'd0, 32'd1);
   endtask

   task automatic go_idle();
      ena = 1'b0;
      step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, r1, dones;
      int st[$];

      rst_n = 1'b0; ena = 1'b0; start = 1'b0; thr_wr = 1'b0; thr_sel = 2'd0;
      thr_data = 8'd0; stray = 1'b0; ack_en = 4'hF;
      vals[0] = 8'd50; vals[1] = 8'd200; vals[2] = 8'd30; vals[3] = 8'd90;
      repeat (3) step();
      chk("reset_outputs", {busy, scan_done, pump_on, fan_on, lamp_on, fault, smp_if.smp_req}, 32'd0);
      rst_n = 1'b1;
      step();

      // Basic scan with literal cycle positions.
      ena = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      chk("t1_req_n1", {smp_if.smp_req, smp_if.smp_ch}, 32'b100);
      repeat (6) step();
      chk("t1_req_ch3_n7", {smp_if.smp_req, smp_if.smp_ch}, 32'b111);
      repeat (2) step();
      chk("t1_busy_n9", {busy, scan_done}, 32'b10);
      step();
      chk("t1_done_n10", {busy, scan_done}, 32'b01);
      chk("t1_actuators", {pump_on, fan_on, lamp_on}, 32'b111);
      chk("t1_fault", fault, 32'd0);
      go_idle();

      // Hysteresis on the pump.
      vals[0] = 8'd102;
      do_scan(lat, r1);
      chk("t2_latency", lat, 32'd10);
      chk("t2_pump_in_band", pump_on, 32'd1);
      go_idle();
      vals[0] = 8'd104;
      do_scan(lat, r1);
      chk("t2_pump_off", pump_on, 32'd0);
      go_idle();

      // Channel 1 timeout, then recovery.
      ack_en = 4'b1101;
      do_scan(lat, r1);
      chk("t3_req_ch1_cycles", r1, 32'd64);
      chk("t3_latency", lat, 32'd73);
      chk("t3_fault", fault, 32'b0010);
      chk("t3_actuators", {pump_on, fan_on, lamp_on}, 32'b001);
      go_idle();
      ack_en = 4'hF;
      do_scan(lat, r1);
      chk("t3_fault_cleared", fault, 32'd0);
      chk("t3_fan_back", fan_on, 32'd1);
      go_idle();

      // Automatic scans every TD cycles; start while busy adds none.
      ena = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         if (c == 36) begin
            chk("t4_busy_at_start", busy, 32'd1);
            start = 1'b1;
         end
         step();
         start = 1'b0;
         if (c >= 17 && smp_if.smp_req && smp_if.smp_ch == 2'd0) st.push_back(c);
      end
      chk("t4_scan_count", st.size(), 32'd4);
      for (int i = 1; i < st.size(); i++) chk("t4_period", st[i] - st[i-1], 32'd16);
      go_idle();
      step();

      // Stray acks while idle are ignored.
      stray = 1'b1;
      repeat (3) step();
      stray = 1'b0;
      step();
      chk("stray_idle", {busy, scan_done, fault}, 32'd0);

      // Abort during channel 2 REQ.
      vals[0] = 8'd10; vals[2] = 8'd200;
      ack_en = 4'b1011;
      ena = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      chk("t5_req_ch2", {smp_if.smp_req, smp_if.smp_ch}, 32'b110);
      ena = 1'b0;
      step();
      chk("t5_abort_next", {smp_if.smp_req, busy}, 32'd0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (scan_done) dones++;
         step();
      end
      chk("t5_no_done", dones, 32'd0);
      chk("t5_actuators_hold", {pump_on, fan_on, lamp_on, fault}, 32'b011_0000);
      ack_en = 4'hF;

      // Threshold write mid-scan is used by DECIDE.
      vals[0] = 8'd50; vals[1] = 8'd200; vals[2] = 8'd30; vals[3] = 8'd90;
      ena = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      thr_wr = 1'b1; thr_sel = 2'd2; thr_data = 8'd20;
      step();
      thr_wr = 1'b0;
      lat = 4;
      while (scan_done !== 1'b1 && lat < 300) begin step(); lat++; end
      chk("t6_latency", lat, 32'd10);
      chk("t6_actuators", {pump_on, fan_on, lamp_on}, 32'b110);
      go_idle();

      // Reset mid-scan clears outputs at once and restores thresholds.
      ena = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      ena = 1'b0;
      #1;
      chk("t6_async_reset", {busy, scan_done, pump_on, fan_on, lamp_on, fault, smp_if.smp_req}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      do_scan(lat, r1);
      chk("t6_thr2_default", {pump_on, fan_on, lamp_on}, 32'b111);
      go_idle();
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/farm_scan_scheduler.md
# farm_scan_scheduler

Periodic scan controller for the precision-farming tile. It shares one sensor-sampling interface (ADC front end) across four channels: soil moisture, temperature, light and humidity. It runs a request/acknowledge handshake per channel, stores the samples, and updates the pump, fan and lamp enables with hysteresis. It sits under `tt_um_precision_farming` and connects the pin-level I/O to the shared sampling datapath.

## Interface
Parameters:
- `TICK_DIV`, 1000: clock cycles between automatic scans (≥ 16).
- `TIMEOUT`, 64: maximum cycles `smp_req` waits for `smp_ack` before a channel is faulted.
- `HYST`, 4: hysteresis band, 8-bit units.

Ports:
- `clk`  in  1  single design clock.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `ena`  in  1  scan enable; low aborts and idles.
- `start`  in  1  single-cycle request for an immediate scan.
- `smp_req`  out  1  sample request to the shared sampler.
- `smp_ch`  out  2  channel being requested (0 moist, 1 temp, 2 light, 3 humid).
- `smp_ack`  in  1  sample valid; `smp_data` is captured when ack is high.
- `smp_data`  in  8  sample value.
- `thr_wr`  in  1  threshold write strobe.
- `thr_sel`  in  2  threshold index.
- `thr_data`  in  8  threshold value.
- `pump_on`, `fan_on`, `lamp_on`  out  1 each  actuator enables.
- `busy`  out  1  high whenever the state machine is not IDLE.
- `scan_done`  out  1  one-cycle pulse when a scan completes.
- `fault`  out  4  per-channel timeout flags, sticky.

## Operation
- States:
  - IDLE → REQ on `start`, or on the tick wrap while `ena` is high.
  - REQ → GAP on ack or on timeout.
  - GAP → REQ for the next channel, or GAP → DECIDE after channel 3.
  - DECIDE → IDLE.
- Tick counter:
  - Free-runs 0..`TICK_DIV`−1 while `ena` is high; it holds at 0 while `ena` is low.
  - A wrap or `start` while `busy` is ignored; no request is queued.
- Handshake:
  - `smp_req` is high only in REQ; `smp_ch` is stable for the whole of REQ.
  - Ack sampled high stores `smp_data` to `sample[ch]` and clears `fault[ch]`.
  - `smp_req` is always low for the one GAP cycle between channels.
  - An ack outside REQ is ignored.
- Timeout:
  - A per-channel counter resets on entering REQ.
  - After `TIMEOUT` REQ cycles with no ack: set `fault[ch]`, keep the old sample, go to GAP.
- DECIDE, using 9-bit arithmetic with the band saturated to 0..255:
  - `pump_on`: set if moist < thr0; clear if moist ≥ thr0+HYST.
  - `fan_on`: set if temp > thr1; clear if temp ≤ thr1−HYST.
  - `lamp_on`: set if light < thr2; clear if light ≥ thr2+HYST.
  - Inside the band, the previous value holds.
  - If a channel's fault bit is set, its actuator is forced to 0.
  - thr3 and humidity are stored only; they drive no actuator.
- Threshold writes:
  - Take effect next cycle and may occur mid-scan; DECIDE uses the current register value.
  - Reset values: thr0=100, thr1=180, thr2=60, thr3=128.
- `ena` falling mid-scan: next state is IDLE, `smp_req` drops next cycle, and the partial samples are kept. Actuators and faults hold; `scan_done` does not pulse.
- Reset: all outputs 0, samples 0, thresholds at their defaults, tick 0, state IDLE.

## Timing
- `start` high in cycle N → `smp_req`=1 with `smp_ch`=0 in N+1.
- Ack in the first REQ cycle gives 2 cycles per channel. For a `start` in cycle N with all four channels acking that way:
  - REQ for channel 3 falls in N+7.
  - DECIDE is N+9.
  - `scan_done`=1 and the new actuator values are visible in N+10; `busy` is low in N+10.
- A timed-out channel occupies REQ for exactly `TIMEOUT` cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `farm_pkg` holds:
  - the state enum (IDLE, REQ, GAP, DECIDE);
  - channel index constants CH_MOIST..CH_HUMID;
  - the default threshold localparams.
- Sub-module `farm_tick_gen`: a parameterised `TICK_DIV` divider with enable, producing a single-cycle `tick`.
- The FSM, sample/threshold register file and decision logic stay in `farm_scan_scheduler`.

## Test plan
- Reset, then `start` with an ack-on-first-cycle sampler returning 50, 200, 30, 90: `scan_done` at N+10; pump=1, fan=1, lamp=1, fault=0.
- Hysteresis: with `pump_on`=1 and thr0=100, rescan with moist=102 → `pump_on` stays 1; rescan with moist=104 → `pump_on`=0.
- Timeout: channel 1 never acks, `TIMEOUT`=64 → `smp_req` high for 64 cycles on ch1; `fault`=4'b0010, `fan_on`=0. A later good ack clears bit 1.
- Auto tick: `TICK_DIV`=16, `ena`=1, no `start` → scans begin every 16 cycles; `start` pulsed while `busy` adds no extra scan.
- Abort: drop `ena` during ch2 REQ → `smp_req`=0 next cycle, `busy`=0, no `scan_done`, actuators unchanged.
- Config: write thr2=20 (`thr_sel`=2) mid-scan, light=30 → `lamp_on`=0 after DECIDE. Assert `rst_n` mid-scan → every output is 0 immediately and thr2 returns to 60.
